riscv: RTL and testbench

- Single-cycle RV32I integer core.
- Fetches one instruction per clock from an external combinational instruction RAM (iram) and accesses an external data RAM (dram) via read/write strobes.
- Top-level CPU in the board: iram on the fetch port, dram on the data port.

---
 rtl/riscv_pkg.sv | 62 ++++++
 rtl/riscv_alu.sv | 33 +++
 rtl/riscv.sv | 157 +++++++++++++++
 tb/tb_riscv.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and the ALU operation set for the riscv core.
// Also holds the funct3/funct7 to ALU-operation mapping used by OP and OP-IMM.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluSll,
      AluSlt,
      AluSltu,
      AluXor,
      AluSrl,
      AluSra,
      AluOr,
      AluAnd,
      AluPassB
   } alu_op_e;

   // alt selects SUB/SRA; callers must only raise it where the encoding allows
   function automatic alu_op_e alu_op_for(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      unique case (funct3)
         F3_ADD_SUB: op = alt ? AluSub : AluAdd;
         F3_SLL:     op = AluSll;
         F3_SLT:     op = AluSlt;
         F3_SLTU:    op = AluSltu;
         F3_XOR:     op = AluXor;
         F3_SRL_SRA: op = alt ? AluSra : AluSrl;
         F3_OR:      op = AluOr;
         F3_AND:     op = AluAnd;
         default:    op = AluAdd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit ALU for the riscv core.
// Shift amounts use only the low 5 bits of operand b.
module riscv_alu
   import riscv_pkg::*;
(
   input  alu_op_e     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      y = '0;
      unique case (op)
         AluAdd:   y = a + b;
         AluSub:   y = a - b;
         AluSll:   y = a << shamt;
         AluSlt:   y = {31'b0, $signed(a) < $signed(b)};
         AluSltu:  y = {31'b0, a < b};
         AluXor:   y = a ^ b;
         AluSrl:   y = a >> shamt;
         AluSra:   y = $signed(a) >>> shamt;
         AluOr:    y = a | b;
         AluAnd:   y = a & b;
         AluPassB: y = b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/riscv.sv
// Single-cycle RV32I core: combinational fetch/decode/execute/memory/writeback,
// with PC and register file committing on the rising clock edge.
module riscv
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] iram_data,
   output logic [31:0] iram_addr,
   output logic        dram_read,
   output logic        dram_write,
   output logic [31:0] dram_addr,
   output logic [31:0] dram_data_out,
   input  logic [31:0] dram_data_in
);

   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] regs [32];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val;

   alu_op_e     alu_op;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        br_taken;
   logic        reg_we;
   logic [31:0] wb_data;
   logic        is_load, is_store;

   assign iram_addr = pc_q;
   assign pc_plus4  = pc_q + 32'd4;

   assign opcode = iram_data[6:0];
   assign rd     = iram_data[11:7];
   assign funct3 = iram_data[14:12];
   assign rs1    = iram_data[19:15];
   assign rs2    = iram_data[24:20];

   assign imm_i = {{20{iram_data[31]}}, iram_data[31:20]};
   assign imm_s = {{20{iram_data[31]}}, iram_data[31:25], iram_data[11:7]};
   assign imm_b = {{19{iram_data[31]}}, iram_data[31], iram_data[7], iram_data[30:25],
                   iram_data[11:8], 1'b0};
   assign imm_u = {iram_data[31:12], 12'b0};
   assign imm_j = {{11{iram_data[31]}}, iram_data[31], iram_data[19:12], iram_data[20],
                   iram_data[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   always_comb begin
      br_taken = 1'b0;
      unique case (funct3)
         F3_BEQ:  br_taken = (rs1_val == rs2_val);
         F3_BNE:  br_taken = (rs1_val != rs2_val);
         F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
         F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         F3_BLTU: br_taken = (rs1_val < rs2_val);
         F3_BGEU: br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_op   = AluAdd;
      alu_a    = rs1_val;
      alu_b    = imm_i;
      reg_we   = 1'b0;
      wb_data  = alu_y;
      pc_d     = pc_plus4;
      is_load  = 1'b0;
      is_store = 1'b0;
      case (opcode)
         OPC_LUI: begin
            alu_op = AluPassB;
            alu_b  = imm_u;
            reg_we = 1'b1;
         end
         OPC_AUIPC: begin
            alu_a  = pc_q;
            alu_b  = imm_u;
            reg_we = 1'b1;
         end
         OPC_JAL: begin
            alu_a   = pc_q;
            alu_b   = imm_j;
            reg_we  = 1'b1;
            wb_data = pc_plus4;
            pc_d    = alu_y;
         end
         OPC_JALR: begin
            reg_we  = 1'b1;
            wb_data = pc_plus4;
            pc_d    = {alu_y[31:1], 1'b0};
         end
         OPC_BRANCH: begin
            alu_a = pc_q;
            alu_b = imm_b;
            if (br_taken) pc_d = alu_y;
         end
         OPC_LOAD: begin
            is_load = 1'b1;
            reg_we  = 1'b1;
            wb_data = dram_data_in;
         end
         OPC_STORE: begin
            alu_b    = imm_s;
            is_store = 1'b1;
         end
         OPC_OP_IMM: begin
            // bit 30 only means "arithmetic" for right shifts; ADDI never subtracts
            alu_op = alu_op_for(funct3, (funct3 == F3_SRL_SRA) && iram_data[30]);
            reg_we = 1'b1;
         end
         OPC_OP: begin
            alu_op = alu_op_for(funct3, iram_data[30]);
            alu_b  = rs2_val;
            reg_we = 1'b1;
         end
         default: ;
      endcase
   end

   riscv_alu u_alu (
      .op (alu_op),
      .a  (alu_a),
      .b  (alu_b),
      .y  (alu_y)
   );

   // Separate address adder keeps dram_addr defined for every opcode
   assign dram_addr     = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
   assign dram_data_out = rs2_val;
   assign dram_read     = is_load & ~reset;
   assign dram_write    = is_store & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (reg_we && (rd != 5'd0)) begin
         regs[rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_riscv.sv
// Directed self-checking bench for the riscv core; the bench plays iram and dram,
// and observes registers by issuing SW and watching dram_data_out.
module tb_riscv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] iram_data = '0;
   logic [31:0] dram_data_in = '0;
   logic [31:0] iram_addr, dram_addr, dram_data_out;
   logic        dram_read, dram_write;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   riscv #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .iram_data     (iram_data),
      .iram_addr     (iram_addr),
      .dram_read     (dram_read),
      .dram_write    (dram_write),
      .dram_addr     (dram_addr),
      .dram_data_out (dram_data_out),
      .dram_data_in  (dram_data_in)
   );

   function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      logic [31:0] v;
      v = imm;
      return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   localparam logic [31:0] NOP = 32'h0000_0013;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins);
      iram_data = ins;
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      issue($urandom);
      tick();
      issue($urandom);
      tick();
      reset = 1'b0;
   endtask

   task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
      issue(enc_s(0, r, 5'd0));
      v = dram_data_out;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1;
      issue($urandom);
      tick();
      issue($urandom);
      n_checks++;
      if (iram_addr !== 32'h0) begin
         $display("FAIL reset_pc got %h want 00000000", iram_addr); n_fail++;
      end
      n_checks++;
      if (dram_write !== 1'b0 || dram_read !== 1'b0) begin
         $display("FAIL reset_strobes got w=%b r=%b want 0/0", dram_write, dram_read); n_fail++;
      end
      tick();
      issue($urandom | 32'h0000_0023);
      n_checks++;
      if (dram_write !== 1'b0) begin
         $display("FAIL reset_store_suppress got %b want 0", dram_write); n_fail++;
      end
      tick();
      reset = 1'b0;
      issue(NOP);
      n_checks++;
      if (iram_addr !== 32'h0) begin
         $display("FAIL reset_release_pc got %h want 00000000", iram_addr); n_fail++;
      end
      for (int r = 1; r < 32; r++) begin
         read_reg(5'(r), v);
         n_checks++;
         if (v !== 32'h0) begin
            $display("FAIL reset_x%0d got %h want 00000000", r, v); n_fail++;
         end
      end
   endtask

   task automatic test_arith();
      logic [31:0] v;
      do_reset();
      issue(enc_i(5, 5'd0, 3'b000, 5'd1, 7'h13)); tick();
      issue(enc_i(-3, 5'd0, 3'b000, 5'd2, 7'h13)); tick();
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3)); tick();
      issue(enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4)); tick();
      issue(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5)); tick();
      issue(enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6)); tick();
      issue(enc_i(32'h401, 5'd2, 3'b101, 5'd7, 7'h13)); tick();
      issue(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd8)); tick();
      issue(enc_i(-1, 5'd2, 3'b100, 5'd9, 7'h13)); tick();
      issue(enc_i(1, 5'd0, 3'b000, 5'd10, 7'h13)); tick();
      issue(enc_r(7'h00, 5'd10, 5'd10, 3'b000, 5'd10)); tick();
      issue(enc_r(7'h00, 5'd10, 5'd10, 3'b000, 5'd10));
      n_checks++;
      if (iram_addr !== 32'h2C) begin
         $display("FAIL arith_pc got %h want 0000002c", iram_addr); n_fail++;
      end
      tick();
      read_reg(5'd3, v);
      n_checks++;
      if (v !== 32'h2) begin $display("FAIL add_x3 got %h want 00000002", v); n_fail++; end
      read_reg(5'd4, v);
      n_checks++;
      if (v !== 32'hFFFF_FFF8) begin $display("FAIL sub_x4 got %h want fffffff8", v); n_fail++; end
      read_reg(5'd5, v);
      n_checks++;
      if (v !== 32'h1) begin $display("FAIL slt_x5 got %h want 00000001", v); n_fail++; end
      read_reg(5'd6, v);
      n_checks++;
      if (v !== 32'h0) begin $display("FAIL sltu_x6 got %h want 00000000", v); n_fail++; end
      read_reg(5'd7, v);
      n_checks++;
      if (v !== 32'hFFFF_FFFE) begin $display("FAIL srai_x7 got %h want fffffffe", v); n_fail++; end
      read_reg(5'd8, v);
      n_checks++;
      if (v !== 32'hA000_0000) begin $display("FAIL sll_x8 got %h want a0000000", v); n_fail++; end
      read_reg(5'd9, v);
      n_checks++;
      if (v !== 32'h2) begin $display("FAIL xori_x9 got %h want 00000002", v); n_fail++; end
      read_reg(5'd10, v);
      n_checks++;
      if (v !== 32'h4) begin $display("FAIL chain_x10 got %h want 00000004", v); n_fail++; end
   endtask

   task automatic test_memory();
      logic [31:0] v;
      do_reset();
      dram_data_in = 32'hDEAD_BEEF;
      issue(enc_i(32'h40, 5'd0, 3'b000, 5'd1, 7'h13));
      n_checks++;
      if (dram_read !== 1'b0 || dram_write !== 1'b0) begin
         $display("FAIL mem_idle_strobes got r=%b w=%b want 0/0", dram_read, dram_write); n_fail++;
      end
      tick();
      issue(enc_i(32'h123, 5'd0, 3'b000, 5'd2, 7'h13)); tick();
      issue(enc_s(4, 5'd2, 5'd1));
      n_checks++;
      if (dram_write !== 1'b1 || dram_read !== 1'b0) begin
         $display("FAIL sw_strobes got w=%b r=%b want 1/0", dram_write, dram_read); n_fail++;
      end
      n_checks++;
      if (dram_addr !== 32'h44) begin $display("FAIL sw_addr got %h want 00000044", dram_addr); n_fail++; end
      n_checks++;
      if (dram_data_out !== 32'h123) begin
         $display("FAIL sw_data got %h want 00000123", dram_data_out); n_fail++;
      end
      tick();
      dram_data_in = 32'h0000_0123;
      issue(enc_i(4, 5'd1, 3'b010, 5'd3, 7'h03));
      n_checks++;
      if (dram_read !== 1'b1 || dram_write !== 1'b0) begin
         $display("FAIL lw_strobes got r=%b w=%b want 1/0", dram_read, dram_write); n_fail++;
      end
      n_checks++;
      if (dram_addr !== 32'h44) begin $display("FAIL lw_addr got %h want 00000044", dram_addr); n_fail++; end
      tick();
      dram_data_in = 32'hDEAD_BEEF;
      read_reg(5'd3, v);
      n_checks++;
      if (v !== 32'h123) begin $display("FAIL lw_x3 got %h want 00000123", v); n_fail++; end
      issue(enc_s(-1, 5'd2, 5'd1));
      n_checks++;
      if (dram_addr !== 32'h3F) begin $display("FAIL sw_unaligned got %h want 0000003f", dram_addr); n_fail++; end
      tick();
   endtask

   task automatic test_control();
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 3; i++) begin issue(NOP); tick(); end
      issue(enc_b(8, 5'd0, 5'd0, 3'b001)); tick();
      n_checks++;
      if (iram_addr !== 32'h10) begin $display("FAIL bne_nt got %h want 00000010", iram_addr); n_fail++; end
      issue(enc_b(8, 5'd0, 5'd0, 3'b000)); tick();
      n_checks++;
      if (iram_addr !== 32'h18) begin $display("FAIL beq_t got %h want 00000018", iram_addr); n_fail++; end
      issue(enc_j(32'h20, 5'd1)); tick();
      n_checks++;
      if (iram_addr !== 32'h38) begin $display("FAIL jal_pc got %h want 00000038", iram_addr); n_fail++; end
      issue(enc_i(1, 5'd1, 3'b000, 5'd0, 7'h67)); tick();
      n_checks++;
      if (iram_addr !== 32'h1C) begin $display("FAIL jalr_pc got %h want 0000001c", iram_addr); n_fail++; end
      read_reg(5'd1, v);
      n_checks++;
      if (v !== 32'h1C) begin $display("FAIL jal_link got %h want 0000001c", v); n_fail++; end
      issue(32'h0000_007F);
      n_checks++;
      if (iram_addr !== 32'h20 || dram_write !== 1'b0 || dram_read !== 1'b0) begin
         $display("FAIL unknown_op got pc=%h w=%b r=%b want 00000020/0/0",
                  iram_addr, dram_write, dram_read);
         n_fail++;
      end
      tick();
      n_checks++;
      if (iram_addr !== 32'h24) begin $display("FAIL unknown_next got %h want 00000024", iram_addr); n_fail++; end
      read_reg(5'd1, v);
      n_checks++;
      if (v !== 32'h1C) begin $display("FAIL unknown_nowrite got %h want 0000001c", v); n_fail++; end
      issue(enc_i(-1, 5'd0, 3'b000, 5'd2, 7'h13)); tick();
      issue(enc_b(12, 5'd2, 5'd0, 3'b110)); tick();
      n_checks++;
      if (iram_addr !== 32'h38) begin $display("FAIL bltu_t got %h want 00000038", iram_addr); n_fail++; end
      issue(enc_b(12, 5'd2, 5'd0, 3'b100)); tick();
      n_checks++;
      if (iram_addr !== 32'h3C) begin $display("FAIL blt_nt got %h want 0000003c", iram_addr); n_fail++; end
      issue(enc_b(-8, 5'd0, 5'd2, 3'b101)); tick();
      n_checks++;
      if (iram_addr !== 32'h40) begin $display("FAIL bge_nt got %h want 00000040", iram_addr); n_fail++; end
      issue(enc_b(-8, 5'd0, 5'd2, 3'b111)); tick();
      n_checks++;
      if (iram_addr !== 32'h38) begin $display("FAIL bgeu_back got %h want 00000038", iram_addr); n_fail++; end
   endtask

   task automatic test_upper();
      logic [31:0] v;
      do_reset();
      issue(enc_u(20'h12345, 5'd1, 7'h37)); tick();
      issue(NOP); tick();
      issue(enc_u(20'h00001, 5'd2, 7'h17)); tick();
      issue(enc_i(7, 5'd0, 3'b000, 5'd0, 7'h13)); tick();
      read_reg(5'd1, v);
      n_checks++;
      if (v !== 32'h1234_5000) begin $display("FAIL lui_x1 got %h want 12345000", v); n_fail++; end
      read_reg(5'd2, v);
      n_checks++;
      if (v !== 32'h0000_1008) begin $display("FAIL auipc_x2 got %h want 00001008", v); n_fail++; end
      read_reg(5'd0, v);
      n_checks++;
      if (v !== 32'h0) begin $display("FAIL x0_zero got %h want 00000000", v); n_fail++; end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      do_reset();
      issue(enc_i(32'h55, 5'd0, 3'b000, 5'd1, 7'h13)); tick();
      issue(NOP); tick();
      reset = 1'b1;
      issue(enc_s(0, 5'd1, 5'd0));
      n_checks++;
      if (dram_write !== 1'b0) begin $display("FAIL midreset_sw got %b want 0", dram_write); n_fail++; end
      tick();
      reset = 1'b0;
      issue(NOP);
      n_checks++;
      if (iram_addr !== 32'h0) begin $display("FAIL midreset_pc got %h want 00000000", iram_addr); n_fail++; end
      read_reg(5'd1, v);
      n_checks++;
      if (v !== 32'h0) begin $display("FAIL midreset_x1 got %h want 00000000", v); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_memory();
      test_control();
      test_upper();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
